// File: rtl/serial_word_rx.sv
// serial_word_rx: receive side of the single-wire serial word link.
//   Synchronizes the idle-high line, recovers start/data/stop framing with
//   mid-bit sampling, and presents each word through a one-word buffer.
// Optional feature: define SERIAL_RX_PARITY_EN to expect an even-parity bit
//   after the data bits (adds the PARITY state and drives parity_err).
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   rx             serial line (asynchronous, idle high)
//   m_data/m_valid/m_ready  word output with valid/ready handshake
//   frame_err      one-cycle pulse, stop bit sampled low
//   overrun        one-cycle pulse, finished word dropped (buffer full)
//   parity_err     one-cycle pulse, parity mismatch (0 without the feature)
//   busy           receiver is inside a frame
module serial_word_rx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic             rx_m_q, rx_s_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sample;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer, preset to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // Bit-time counter reaches 0 exactly on each mid-bit sample point.
  assign sample = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CW'(HALF - 1);
`ifdef SERIAL_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      START: begin
        if (!sample) cnt_d = cnt_q - CW'(1);
        else if (rx_s_q) state_d = IDLE;  // false start, silently ignored
        else begin
          state_d = DATA;
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          bit_d   = '0;
        end
      end
      DATA: begin
        if (!sample) cnt_d = cnt_q - CW'(1);
        else begin
          // LSB first: each new bit enters at the top and shifts down.
          shift_d = (shift_q >> 1) | (WIDTH'(rx_s_q) << (WIDTH - 1));
          cnt_d   = CW'(CLKS_PER_BIT - 1);
`ifdef SERIAL_RX_PARITY_EN
          par_d   = par_q ^ rx_s_q;
`endif
          if (bit_q == BW'(WIDTH - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + BW'(1);
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (!sample) cnt_d = cnt_q - CW'(1);
        else begin
          par_d   = par_q ^ rx_s_q;  // even parity: running XOR ends at 0
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!sample) cnt_d = cnt_q - CW'(1);
        else begin
          // Back to IDLE mid stop bit so an immediately following start
          // edge is not missed.
          state_d = IDLE;
          if (!rx_s_q) frame_err_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          else if (par_q) parity_err_d = 1'b1;
`endif
          else if (!m_valid_q || m_ready) begin
            m_data_d  = shift_q;
            m_valid_d = 1'b1;
          end else overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed scenarios plus a
// randomized frame stream compared against a frame-level reference model.
module tb_serial_word_rx;
  localparam int W = 8;
  localparam int C = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Cycles from the cycle rx is driven low to the first cycle m_valid is
  // high: 2 synchronizer cycles, half a bit, start+data(+parity) bits, +1.
  localparam int LAT = 2 + C/2 + (W + 1 + PAR) * C + 1;

  logic clk = 1'b0;
  logic rstn, rx, m_ready;
  logic [W-1:0] m_data;
  logic m_valid, frame_err, overrun, parity_err, busy;

  serial_word_rx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .busy(busy));

  always #5 clk = ~clk;

  int pass_cnt = 0, tot_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: only this block writes these, tasks read deltas.
  int n_xfer = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_vcyc = 0, n_viol = 0;
  int rise_cyc = -1, fe_cyc = -1;
  logic [W-1:0] xfer_d [0:255];
  logic mv_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0, pe_p = 1'b0;
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      xfer_d[n_xfer % 256] <= m_data;
      n_xfer <= n_xfer + 1;
    end
    if (m_valid) n_vcyc <= n_vcyc + 1;
    if (m_valid && !mv_p) rise_cyc <= cyc;
    if (frame_err) begin n_fe <= n_fe + 1; fe_cyc <= cyc; end
    if (overrun) n_ov <= n_ov + 1;
    if (parity_err) n_pe <= n_pe + 1;
    if ((frame_err && fe_p) || (overrun && ov_p) || (parity_err && pe_p) ||
        (frame_err && overrun)) n_viol <= n_viol + 1;
    mv_p <= m_valid; fe_p <= frame_err; ov_p <= overrun; pe_p <= parity_err;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (C) begin @(posedge clk); #1; end
  endtask

  // Drives one full frame; c returns the cycle the start bit began.
  task automatic send_frame(input logic [W-1:0] d, input logic stop_bit,
                            input logic par_bad, output int c);
    c = cyc;
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    if (PAR != 0) send_bit((^d) ^ par_bad);
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    rstn = 1'b0; rx = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tot_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else pass_cnt++;
    tot_cnt++; if (m_data !== '0) $display("FAIL reset_m_data: got %h want 00", m_data); else pass_cnt++;
    tot_cnt++; if ({busy, frame_err, overrun, parity_err} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {busy, frame_err, overrun, parity_err}); else pass_cnt++;
    rstn = 1'b1;
    idle(2 * C);
  endtask

  task automatic test_basic;
    int c, x0, v0, e0;
    x0 = n_xfer; v0 = n_vcyc; e0 = n_fe + n_ov + n_pe;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, c);
    idle(3 * C);
    tot_cnt++; if (rise_cyc !== c + LAT) $display("FAIL basic_latency: got %0d want %0d", rise_cyc - c, LAT); else pass_cnt++;
    tot_cnt++; if (n_vcyc - v0 !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", n_vcyc - v0); else pass_cnt++;
    tot_cnt++; if (n_xfer - x0 !== 1 || xfer_d[x0 % 256] !== 8'hA5)
      $display("FAIL basic_data: got n=%0d d=%h want n=1 d=a5", n_xfer - x0, xfer_d[x0 % 256]); else pass_cnt++;
    tot_cnt++; if (n_fe + n_ov + n_pe - e0 !== 0) $display("FAIL basic_errors: got %0d want 0", n_fe + n_ov + n_pe - e0); else pass_cnt++;
  endtask

  task automatic test_false_start;
    int x0, f0;
    logic b_seen;
    x0 = n_xfer; f0 = n_fe; b_seen = 1'b0;
    rx = 1'b0; @(posedge clk); #1; rx = 1'b1;
    repeat (6) begin @(negedge clk); if (busy) b_seen = 1'b1; end
    idle(2 * C);
    tot_cnt++; if (b_seen !== 1'b1) $display("FAIL false_start_busy_seen: got %b want 1", b_seen); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL false_start_busy_end: got %b want 0", busy); else pass_cnt++;
    tot_cnt++; if (n_xfer - x0 !== 0 || n_fe - f0 !== 0)
      $display("FAIL false_start_outputs: got xfer=%0d fe=%0d want 0 0", n_xfer - x0, n_fe - f0); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int c, x0, f0, v0;
    x0 = n_xfer; f0 = n_fe; v0 = n_vcyc;
    send_frame(8'h3C, 1'b0, 1'b0, c);
    idle(3 * C);
    tot_cnt++; if (n_fe - f0 !== 1 || fe_cyc !== c + LAT)
      $display("FAIL frame_err_pulse: got n=%0d at %0d want n=1 at %0d", n_fe - f0, fe_cyc - c, LAT); else pass_cnt++;
    tot_cnt++; if (n_vcyc - v0 !== 0) $display("FAIL frame_err_no_valid: got %0d want 0", n_vcyc - v0); else pass_cnt++;
    send_frame(8'h3D, 1'b1, 1'b0, c);
    idle(3 * C);
    tot_cnt++; if (n_xfer - x0 !== 1 || xfer_d[x0 % 256] !== 8'h3D)
      $display("FAIL frame_err_recover: got n=%0d d=%h want n=1 d=3d", n_xfer - x0, xfer_d[x0 % 256]); else pass_cnt++;
  endtask

  task automatic test_overrun;
    int c, x0, o0;
    x0 = n_xfer; o0 = n_ov;
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, c);
    idle(C);
    send_frame(8'h22, 1'b1, 1'b0, c);
    idle(3 * C);
    tot_cnt++; if (n_ov - o0 !== 1) $display("FAIL overrun_count: got %0d want 1", n_ov - o0); else pass_cnt++;
    tot_cnt++; if (m_valid !== 1'b1 || m_data !== 8'h11)
      $display("FAIL overrun_hold: got v=%b d=%h want v=1 d=11", m_valid, m_data); else pass_cnt++;
    m_ready = 1'b1;
    @(posedge clk); #1;
    tot_cnt++; if (m_valid !== 1'b0) $display("FAIL overrun_valid_fall: got %b want 0", m_valid); else pass_cnt++;
    idle(1);
    tot_cnt++; if (n_xfer - x0 !== 1 || xfer_d[x0 % 256] !== 8'h11)
      $display("FAIL overrun_accept: got n=%0d d=%h want n=1 d=11", n_xfer - x0, xfer_d[x0 % 256]); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int c, x0, e0;
    x0 = n_xfer; e0 = n_fe + n_ov + n_pe;
    m_ready = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0, c);
    send_frame(8'hFF, 1'b1, 1'b0, c);
    idle(3 * C);
    tot_cnt++; if (n_xfer - x0 !== 2 || xfer_d[x0 % 256] !== 8'h00 || xfer_d[(x0 + 1) % 256] !== 8'hFF)
      $display("FAIL back_to_back: got n=%0d %h %h want n=2 00 ff", n_xfer - x0,
               xfer_d[x0 % 256], xfer_d[(x0 + 1) % 256]); else pass_cnt++;
    tot_cnt++; if (n_fe + n_ov + n_pe - e0 !== 0) $display("FAIL back_to_back_errors: got %0d want 0", n_fe + n_ov + n_pe - e0); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    int c, x0, e0;
    logic [W-1:0] d;
    d = 8'h5A;
    m_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, c);  // leaves a word held
    idle(C);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    #2 rstn = 1'b0;
    #1;
    tot_cnt++; if ({m_valid, busy, frame_err, overrun, parity_err} !== 5'b0 || m_data !== '0)
      $display("FAIL mid_reset_outputs: got v=%b b=%b d=%h want all 0", m_valid, busy, m_data); else pass_cnt++;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    x0 = n_xfer; e0 = n_fe + n_ov + n_pe;
    m_ready = 1'b1;
    idle(2 * C);
    send_frame(8'h5A, 1'b1, 1'b0, c);
    idle(3 * C);
    tot_cnt++; if (n_xfer - x0 !== 1 || xfer_d[x0 % 256] !== 8'h5A || n_fe + n_ov + n_pe - e0 !== 0)
      $display("FAIL mid_reset_recover: got n=%0d d=%h err=%0d want n=1 d=5a err=0",
               n_xfer - x0, xfer_d[x0 % 256], n_fe + n_ov + n_pe - e0); else pass_cnt++;
    if (PAR != 0) begin
      x0 = n_xfer; e0 = n_pe;
      send_frame(8'h5A, 1'b1, 1'b1, c);
      idle(3 * C);
      tot_cnt++; if (n_pe - e0 !== 1 || n_xfer - x0 !== 0)
        $display("FAIL parity_err: got pe=%0d xfer=%0d want 1 0", n_pe - e0, n_xfer - x0); else pass_cnt++;
    end
  endtask

  // Frame-level reference: a bad stop bit gives frame_err, otherwise a bad
  // parity bit gives parity_err, otherwise the word arrives (m_ready=1).
  task automatic test_random;
    int c, x0, f0, p0, o0, exp_fe, exp_pe, exp_n, bad;
    logic [W-1:0] exp_w [0:31];
    logic [W-1:0] d;
    logic stop_ok, par_bad;
    x0 = n_xfer; f0 = n_fe; p0 = n_pe; o0 = n_ov;
    exp_fe = 0; exp_pe = 0; exp_n = 0; bad = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = W'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_bad = (PAR != 0) && ($urandom_range(0, 3) == 0);
      send_frame(d, stop_ok, par_bad, c);
      if (!stop_ok) exp_fe++;
      else if (par_bad) exp_pe++;
      else begin exp_w[exp_n] = d; exp_n++; end
      if (!stop_ok) idle(C + $urandom_range(0, 2 * C));
      else idle($urandom_range(0, 2 * C));
    end
    idle(3 * C);
    tot_cnt++; if (n_xfer - x0 !== exp_n) $display("FAIL random_count: got %0d want %0d", n_xfer - x0, exp_n); else pass_cnt++;
    for (int i = 0; i < exp_n; i++)
      if (xfer_d[(x0 + i) % 256] !== exp_w[i]) bad++;
    tot_cnt++; if (bad !== 0) $display("FAIL random_data: got %0d wrong words want 0", bad); else pass_cnt++;
    tot_cnt++; if (n_fe - f0 !== exp_fe || n_pe - p0 !== exp_pe || n_ov - o0 !== 0)
      $display("FAIL random_errors: got fe=%0d pe=%0d ov=%0d want %0d %0d 0",
               n_fe - f0, n_pe - p0, n_ov - o0, exp_fe, exp_pe); else pass_cnt++;
    tot_cnt++; if (n_viol !== 0) $display("FAIL pulse_shape: got %0d violations want 0", n_viol); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receive side of the team's single-wire serial word link. Samples an asynchronous idle-high line, recovers start/data/stop framing, and presents each received word on a valid/ready output with a one-word holding buffer.
- Sits between the transmitter's output pin and any parallel consumer. Reports framing errors and overruns as single-cycle pulses.

Parameters:
- WIDTH, 8, data bits per frame, sent LSB first; WIDTH >= 1.
- CLKS_PER_BIT, 4, clk cycles per serial bit; CLKS_PER_BIT >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- rx  input  1  serial line; asynchronous to clk; idle high.
- m_data  output  WIDTH  received word; stable while m_valid=1.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  consumer accepts; transfer occurs when m_valid && m_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.
- parity_err  output  1  one-cycle pulse, parity mismatch (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State goes to IDLE.
  - Counters clear.
  - The 2-flop rx synchronizer presets to 1.
  - m_data=0, m_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
- Reset mid-frame aborts the frame; no output and no error pulse for it.
- rx passes through a 2-flop synchronizer; rx_s is its output. All decisions use rx_s.
- Definition: t0 is the first cycle in IDLE with rx_s=0. Bit k (k=0 is the start bit) is sampled at cycle t0 + CLKS_PER_BIT/2 (integer divide) + k*CLKS_PER_BIT.
- FSM states:
  - IDLE: on rx_s=0, go to START and load the bit counter.
  - START: at the sample point, rx_s=0 goes to DATA. rx_s=1 is a false start: go to IDLE, no error flagged.
  - DATA: at each sample point, shift rx_s in LSB first. After WIDTH samples, go to PARITY if the feature is compiled in, otherwise to STOP.
  - PARITY: one sample, then go to STOP.
  - STOP:
    - At the sample point, go straight to IDLE. There is no wait for the end of the stop bit, so a start bit directly following is caught.
    - rx_s=1 delivers the word.
    - rx_s=0 pulses frame_err for one cycle and drops the word.
- Delivery: occurs on the cycle after the stop sample.
  - If m_valid=0, or m_valid && m_ready in that cycle: load m_data and set m_valid=1.
  - Otherwise: pulse overrun; the held word and m_valid are unchanged.
- Latency, no parity: m_valid rises at t0 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT + 1. With defaults this is t0+39.
- Handshake:
  - m_valid falls the cycle after m_valid && m_ready, unless a delivery coincides.
  - Simultaneous accept and delivery: m_valid stays 1, m_data takes the new word, no overrun.
- Errors:
  - frame_err and overrun never assert in the same cycle; they belong to different outcomes.
  - frame_err, overrun and parity_err never stretch beyond one cycle.
- rx activity while busy, other than at sample points, is ignored.

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- Defined:
  - Each frame carries an even-parity bit after the data bits, and the PARITY state is present.
  - All later sample points shift by one bit time (defaults: m_valid at t0+43).
  - On mismatch, parity_err pulses in the delivery cycle and the word is dropped. frame_err takes priority if the stop bit is also bad.
- Undefined: no PARITY state, and parity_err is tied to 0.

Test Plan:
1. Defaults, m_ready=1, frame 0xA5 with good stop bit -> m_valid high for exactly 1 cycle at t0+39, m_data=0xA5, no error pulses.
2. rx low for 1 clk, then high -> busy rises then returns to 0 after the START sample; no m_valid, no frame_err.
3. Frame 0x3C with stop bit 0 -> frame_err 1-cycle pulse at t0+39; m_valid stays 0; the next frame 0x3D is received correctly.
4. m_ready=0; frames 0x11 then 0x22 -> m_data holds 0x11 and overrun pulses once at the second delivery. Then m_ready=1 -> 0x11 accepted and m_valid falls the next cycle.
5. Back-to-back frames 0x00 then 0xFF (stop bit exactly one bit time), m_ready=1 -> both delivered in order, no errors.
6. rstn pulsed low during DATA of a frame -> all outputs 0 immediately, busy=0. After release, frame 0x5A is received correctly. With SERIAL_RX_PARITY_EN, a wrong parity bit on 0x5A -> parity_err pulse and no m_valid.
